// File: rtl/reorder_buffer.sv
// In-order retirement buffer that sits after rename. Entries are allocated at the tail.
// Execute marks them done, and the oldest done entry retires, one per cycle.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_has_dest,
  input  logic [AREG_W-1:0] alloc_dr,
  input  logic [PREG_W-1:0] alloc_dr_p,
  input  logic [PREG_W-1:0] alloc_old_dr,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_rob_num,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_rob_num,
  output logic              retire_valid,
  output logic [IDX_W-1:0]  retire_rob_num,
  output logic [AREG_W-1:0] retire_dr,
  output logic [PREG_W-1:0] retire_dr_p,
  output logic [63:0]       retire_free_vec,
  output logic [IDX_W:0]    count
);

  typedef struct packed {
    logic              has_dest;
    logic [AREG_W-1:0] dr;
    logic [PREG_W-1:0] dr_p;
    logic [PREG_W-1:0] old_dr;
  } rob_entry_t;

  rob_entry_t       ent [DEPTH];
  logic [DEPTH-1:0] ent_valid, ent_done;
  logic [IDX_W:0]   head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             alloc_fire, retire_fire;
  rob_entry_t       head_ent;

  assign head_idx      = head[IDX_W-1:0];
  assign tail_idx      = tail[IDX_W-1:0];
  assign head_ent      = ent[head_idx];
  assign alloc_ready   = (count != (IDX_W+1)'(DEPTH));
  assign alloc_rob_num = tail_idx;
  assign alloc_fire    = alloc_valid && alloc_ready;
  // Retire looks only at registered done, so a completion lands one cycle before it can retire.
  assign retire_fire   = ent_valid[head_idx] && ent_done[head_idx];

  // Payload needs no reset; it is only observed behind ent_valid.
  always_ff @(posedge clk) begin
    if (alloc_fire)
      ent[tail_idx] <= '{has_dest: alloc_has_dest, dr: alloc_dr,
                         dr_p: alloc_dr_p, old_dr: alloc_old_dr};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_valid       <= '0;
      ent_done        <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      retire_valid    <= 1'b0;
      retire_rob_num  <= '0;
      retire_dr       <= '0;
      retire_dr_p     <= '0;
      retire_free_vec <= '0;
    end else begin
      if (cmpl_valid && ent_valid[cmpl_rob_num])
        ent_done[cmpl_rob_num] <= 1'b1;

      if (retire_fire) begin
        ent_valid[head_idx] <= 1'b0;
        head                <= head + 1'b1;
        retire_valid        <= 1'b1;
        retire_rob_num      <= head_idx;
        retire_dr           <= head_ent.dr;
        retire_dr_p         <= head_ent.dr_p;
        // p0 doubles as "no previous mapping" and must never return to the free pool.
        retire_free_vec     <= (head_ent.has_dest && head_ent.old_dr != '0)
                               ? (64'd1 << head_ent.old_dr) : 64'd0;
      end else begin
        retire_valid    <= 1'b0;
        retire_free_vec <= '0;
      end

      // Alloc is placed after cmpl, so a stale completion cannot mark a fresh entry done.
      if (alloc_fire) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= 1'b0;
        tail                <= tail + 1'b1;
      end

      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic.
// Both are scored against a program-order queue model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, flush, alloc_valid, alloc_has_dest, cmpl_valid;
  logic [4:0]  alloc_dr;
  logic [5:0]  alloc_dr_p, alloc_old_dr;
  logic [3:0]  cmpl_rob_num;
  logic        alloc_ready, retire_valid;
  logic [3:0]  alloc_rob_num, retire_rob_num;
  logic [4:0]  retire_dr;
  logic [5:0]  retire_dr_p;
  logic [63:0] retire_free_vec;
  logic [4:0]  count;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest),
    .alloc_dr(alloc_dr), .alloc_dr_p(alloc_dr_p), .alloc_old_dr(alloc_old_dr),
    .alloc_ready(alloc_ready), .alloc_rob_num(alloc_rob_num),
    .cmpl_valid(cmpl_valid), .cmpl_rob_num(cmpl_rob_num),
    .retire_valid(retire_valid), .retire_rob_num(retire_rob_num),
    .retire_dr(retire_dr), .retire_dr_p(retire_dr_p),
    .retire_free_vec(retire_free_vec), .count(count)
  );

  always #5 clk = ~clk;

  // Model: live instructions held oldest-first.
  typedef struct { int idx; bit hd; int dr; int drp; int old; bit done; } ent_t;
  ent_t        q[$];
  int          tail_m;
  bit          m_rv;
  int          m_rnum, m_dr, m_drp;
  logic [63:0] m_free;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
  endtask

  task automatic model_step();
    bit   ret, rdy;
    ent_t h, n;
    if (rst || flush) begin
      q.delete(); tail_m = 0; m_rv = 0; m_rnum = 0; m_dr = 0; m_drp = 0; m_free = '0;
      return;
    end
    rdy = q.size() < DEPTH;
    ret = q.size() > 0 && q[0].done;
    if (ret) begin
      h = q[0];
      m_rv = 1; m_rnum = h.idx; m_dr = h.dr; m_drp = h.drp;
      m_free = (h.hd && h.old != 0) ? (64'd1 << h.old) : 64'd0;
    end else begin
      m_rv = 0; m_free = '0;
    end
    if (cmpl_valid)
      foreach (q[i]) if (q[i].idx == int'(cmpl_rob_num)) q[i].done = 1;
    if (ret) void'(q.pop_front());
    if (alloc_valid && rdy) begin
      n.idx = tail_m; n.hd = alloc_has_dest; n.dr = int'(alloc_dr);
      n.drp = int'(alloc_dr_p); n.old = int'(alloc_old_dr); n.done = 0;
      q.push_back(n);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    chk("count",     64'(count),           64'(q.size()));
    chk("ready",     64'(alloc_ready),     64'(q.size() < DEPTH));
    chk("rob_num",   64'(alloc_rob_num),   64'(tail_m));
    chk("ret_valid", 64'(retire_valid),    64'(m_rv));
    chk("ret_num",   64'(retire_rob_num),  64'(m_rnum));
    chk("ret_dr",    64'(retire_dr),       64'(m_dr));
    chk("ret_dr_p",  64'(retire_dr_p),     64'(m_drp));
    chk("free_vec",  retire_free_vec,      m_free);
  endtask

  task automatic cyc(input bit av, input bit hd, input int dr, input int drp, input int old,
                     input bit cv, input int ci, input bit fl, input bit rs);
    alloc_valid = av; alloc_has_dest = hd; alloc_dr = 5'(dr);
    alloc_dr_p = 6'(drp); alloc_old_dr = 6'(old);
    cmpl_valid = cv; cmpl_rob_num = 4'(ci); flush = fl; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();                          cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset();                         cyc(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic alloc(input int dr, input int drp, input int old, input bit hd);
    cyc(1, hd, dr, drp, old, 0, 0, 0, 0);
  endtask
  task automatic cmpl(input int i);               cyc(0, 0, 0, 0, 0, 1, i, 0, 0); endtask

  initial begin
    // Reset state
    reset(); reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);

    // Single instruction: done at one edge, retired at the next
    alloc(5, 33, 5, 1);
    cmpl(0);
    chk("t2_early", 64'(retire_valid), 64'd0);
    idle();
    chk("t2_rv", 64'(retire_valid), 64'd1);
    chk("t2_drp", 64'(retire_dr_p), 64'd33);
    chk("t2_free", retire_free_vec, 64'h20);
    idle();

    // Out-of-order completion still retires in program order
    reset();
    alloc(1, 10, 11, 1); alloc(2, 12, 13, 1); alloc(3, 14, 15, 1);
    cmpl(2); cmpl(1); cmpl(0);
    idle();
    chk("t3_first", 64'(retire_rob_num), 64'd0);
    idle(); idle(); idle();

    // Fill, overflow attempt, then wrap
    reset();
    for (int i = 0; i < DEPTH; i++) alloc(i, 20 + i, 40 + i, 1);
    chk("t4_full", 64'(alloc_ready), 64'd0);
    alloc(7, 7, 7, 1);
    chk("t4_cnt16", 64'(count), 64'd16);
    cmpl(0); idle();
    chk("t4_cnt15", 64'(count), 64'd15);
    alloc(9, 50, 51, 1);
    for (int i = 1; i < DEPTH; i++) cmpl(i);
    cmpl(0);
    repeat (4) idle();

    // Stores and old_dr=0 free nothing; completion of an unallocated index is ignored
    reset();
    alloc(4, 30, 31, 0); alloc(6, 32, 0, 1);
    cmpl(9);
    cmpl(0); cmpl(1);
    idle();
    chk("t5_free0", retire_free_vec, 64'd0);
    idle(); idle();

    // Flush discards live and done entries and beats a same-cycle alloc/cmpl
    reset();
    for (int i = 0; i < 5; i++) alloc(i, i + 1, i + 2, 1);
    cmpl(1); cmpl(2);
    cyc(1, 1, 3, 3, 3, 1, 0, 1, 0);
    chk("t6_cnt", 64'(count), 64'd0);
    chk("t6_num", 64'(alloc_rob_num), 64'd0);
    idle(); idle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int ci;
      ci = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].idx
                                                    : int'($urandom_range(15));
      cyc($urandom_range(2) != 0, 1'($urandom), int'($urandom_range(31)),
          int'($urandom_range(63)), int'($urandom_range(63)) & ($urandom_range(7) == 0 ? 0 : 63),
          1'($urandom), ci, $urandom_range(149) == 0, $urandom_range(499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
